// File: rtl/dct_input_folder_if.sv
// Stream-in / DCT-out bundle for dct_input_folder.
//   s_valid, s_data, s_sync, s_ready : serial sample stream with valid/ready handshake
//   dct_start, dct_in_a, dct_in_b,
//   dct_active, realign              : folded pair stream towards the DCT core
// Modports: master = sample producer / DCT consumer side, slave = the folder itself.
interface dct_input_folder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_sync;
  logic              s_ready;
  logic              dct_start;
  logic [DATA_W-1:0] dct_in_a;
  logic [DATA_W-1:0] dct_in_b;
  logic              dct_active;
  logic              realign;

  modport master (
    output s_valid, s_data, s_sync,
    input  s_ready, dct_start, dct_in_a, dct_in_b, dct_active, realign
  );

  modport slave (
    input  s_valid, s_data, s_sync,
    output s_ready, dct_start, dct_in_a, dct_in_b, dct_active, realign
  );
endinterface

// File: rtl/dct_input_folder.sv
// Input folder for the 16-point DCT core. Buffers serial samples into a ping-pong pair of
// N-sample banks and replays each full bank as N/2 folded pairs (x[k], x[N-1-k]), one per clock,
// with dct_start on pair 0. Consecutive starts are spaced by at least max(MIN_START_GAP, N/2).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of dct_input_folder_if (sample stream in, folded pairs out)
module dct_input_folder #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned N             = 16,
  parameter int unsigned MIN_START_GAP = 16
) (
  input logic               clk,
  input logic               reset,
  dct_input_folder_if.slave bus
);
  localparam int unsigned Pairs = N / 2;
  localparam int unsigned Gap   = (MIN_START_GAP > Pairs) ? MIN_START_GAP : Pairs;
  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned KW    = (Pairs > 1) ? $clog2(Pairs) : 1;
  localparam int unsigned GapW  = $clog2(Gap + 1);

  localparam logic [IdxW-1:0] IdxFirst = '0;
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  logic [DATA_W-1:0] mem_q [2][N];

  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic              rbank_q, rbank_d;
  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              realign_q;
  logic              start_q, start_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;

  logic            accept, resync, blk_done;
  logic [IdxW-1:0] waddr, ka, kb;
  logic            last_pair, nbank, launch, gap_ok;

  // Ready only when the bank being filled has been drained; forced low in reset.
  assign bus.s_ready = reset & ~full_q[wbank_q];

  assign accept   = bus.s_valid & bus.s_ready;
  // A sync in the middle of a block throws the partial block away and restarts at index 0.
  assign resync   = accept & bus.s_sync & (widx_q != '0);
  assign blk_done = accept & ~resync & (widx_q == IdxLast);
  assign waddr    = resync ? IdxFirst : widx_q;

  // gap_q counts cycles since the last dct_start; launching now puts the start one cycle later.
  assign gap_ok    = gap_q >= GapW'(Gap - 1);
  assign last_pair = (state_q == StStream) && (k_q == KW'(Pairs - 1));
  // On the last pair the current bank is released, so the candidate is the other bank.
  assign nbank     = last_pair ? ~rbank_q : rbank_q;
  assign launch    = ((state_q == StIdle) || last_pair) && full_q[nbank] && gap_ok;
  assign ka        = IdxW'(k_q) + 1'b1;
  assign kb        = IdxW'(N - 2) - IdxW'(k_q);

  always_comb begin
    widx_d  = widx_q;
    wbank_d = wbank_q;
    if (resync) begin
      widx_d = IdxW'(1);
    end else if (blk_done) begin
      widx_d  = '0;
      wbank_d = ~wbank_q;
    end else if (accept) begin
      widx_d = widx_q + 1'b1;
    end
  end

  always_comb begin
    full_d = full_q;
    if (last_pair) full_d[rbank_q] = 1'b0;
    if (blk_done)  full_d[wbank_q] = 1'b1;
  end

  // Outputs are registered: the values loaded here are what the DCT sees next cycle.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rbank_d  = rbank_q;
    start_d  = 1'b0;
    active_d = 1'b0;
    a_d      = '0;
    b_d      = '0;
    if (launch) begin
      state_d  = StStream;
      k_d      = '0;
      rbank_d  = nbank;
      start_d  = 1'b1;
      active_d = 1'b1;
      a_d      = mem_q[nbank][IdxFirst];
      b_d      = mem_q[nbank][IdxLast];
    end else if (last_pair) begin
      state_d = StIdle;
      rbank_d = ~rbank_q;
    end else if (state_q == StStream) begin
      k_d      = k_q + 1'b1;
      active_d = 1'b1;
      a_d      = mem_q[rbank_q][ka];
      b_d      = mem_q[rbank_q][kb];
    end
  end

  always_comb begin
    if (launch) begin
      gap_d = '0;
    end else if (gap_q == GapW'(Gap)) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wbank_q][waddr] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      wbank_q   <= 1'b0;
      widx_q    <= '0;
      rbank_q   <= 1'b0;
      state_q   <= StIdle;
      k_q       <= '0;
      gap_q     <= GapW'(Gap);
      realign_q <= 1'b0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      widx_q    <= widx_d;
      rbank_q   <= rbank_d;
      state_q   <= state_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      realign_q <= resync;
      start_q   <= start_d;
      active_q  <= active_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign bus.dct_start  = start_q;
  assign bus.dct_active = active_q;
  assign bus.dct_in_a   = a_q;
  assign bus.dct_in_b   = b_q;
  assign bus.realign    = realign_q;
endmodule

// File: tb/tb_dct_input_folder.sv
// Bench for dct_input_folder: dut0 uses default parameters, dut1 uses MIN_START_GAP=40.
// A block-level model turns accepted samples into the expected pair schedule per instance.
module tb_dct_input_folder;
  localparam int N = 16;
  localparam int P = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_input_folder_if #(.DATA_W(8)) bus0 ();
  dct_input_folder_if #(.DATA_W(8)) bus1 ();

  dct_input_folder #(.DATA_W(8), .N(16), .MIN_START_GAP(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dct_input_folder #(.DATA_W(8), .N(16), .MIN_START_GAP(40)) dut_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic       vld [2];
  logic [7:0] dat [2];
  logic       syn [2];
  logic       rdy [2];
  logic       st  [2];
  logic       act [2];
  logic       rlg [2];
  logic [7:0] oa  [2];
  logic [7:0] ob  [2];

  assign bus0.s_valid = vld[0];
  assign bus0.s_data  = dat[0];
  assign bus0.s_sync  = syn[0];
  assign bus1.s_valid = vld[1];
  assign bus1.s_data  = dat[1];
  assign bus1.s_sync  = syn[1];
  assign rdy[0] = bus0.s_ready;
  assign st[0]  = bus0.dct_start;
  assign act[0] = bus0.dct_active;
  assign rlg[0] = bus0.realign;
  assign oa[0]  = bus0.dct_in_a;
  assign ob[0]  = bus0.dct_in_b;
  assign rdy[1] = bus1.s_ready;
  assign st[1]  = bus1.dct_start;
  assign act[1] = bus1.dct_active;
  assign rlg[1] = bus1.realign;
  assign oa[1]  = bus1.dct_in_a;
  assign ob[1]  = bus1.dct_in_b;

  int total = 0;
  int bad = 0;

  // Model state. Expected entries pack {pad, cycle[31:0], start, a[7:0], b[7:0]}.
  logic [7:0]      part [2][N];
  int              pcnt [2];
  longint unsigned expq [2][$];
  int              last_exp_start [2];
  bit              have_last [2];
  int              exp_realign [2];
  int              gap_of [2];
  int              blocks_made [2];
  int              realigns_made [2];
  int              last_acc [2];
  int              stalls [2];
  // Observation counters.
  int              starts_seen [2];
  int              active_seen [2];
  int              realign_seen [2];
  int              last_start_seen [2];
  int              prev_start [2];
  int              min_gap [2];
  int              max_gap [2];
  logic [7:0]      first_a [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      pcnt[d] = 0;
      expq[d].delete();
      have_last[d] = 1'b0;
      exp_realign[d] = -1;
      prev_start[d] = -1;
      min_gap[d] = 1 << 30;
      max_gap[d] = 0;
    end
    gap_of[0] = 16;
    gap_of[1] = 40;
  endfunction

  function automatic void model_accept(int d, logic [7:0] x, logic sync, int c);
    int s;
    if (sync && pcnt[d] != 0) begin
      pcnt[d] = 0;
      exp_realign[d] = c + 1;
      realigns_made[d]++;
    end
    part[d][pcnt[d]] = x;
    pcnt[d]++;
    last_acc[d] = c;
    if (pcnt[d] == N) begin
      s = c + 2;
      if (have_last[d] && last_exp_start[d] + gap_of[d] > s) s = last_exp_start[d] + gap_of[d];
      last_exp_start[d] = s;
      have_last[d] = 1'b1;
      blocks_made[d]++;
      for (int k = 0; k < P; k++)
        expq[d].push_back({15'd0, 32'(s + k), (k == 0), part[d][k], part[d][N-1-k]});
      pcnt[d] = 0;
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        for (int d = 0; d < 2; d++) begin
          longint unsigned e;
          logic       xact, xst;
          logic [7:0] xa, xb;
          xact = 1'b0; xst = 1'b0; xa = '0; xb = '0;
          if (expq[d].size() != 0) begin
            e = expq[d][0];
            if (int'(e[48:17]) == cyc) begin
              void'(expq[d].pop_front());
              xact = 1'b1; xst = e[16]; xa = e[15:8]; xb = e[7:0];
            end
          end
          total++;
          if (act[d] !== xact || st[d] !== xst || oa[d] !== xa || ob[d] !== xb) begin
            bad++;
            $display("FAIL pair dut%0d cyc=%0d got act=%b start=%b a=%0d b=%0d want act=%b start=%b a=%0d b=%0d",
                     d, cyc, act[d], st[d], oa[d], ob[d], xact, xst, xa, xb);
          end
          total++;
          if (rlg[d] !== (cyc == exp_realign[d])) begin
            bad++;
            $display("FAIL realign dut%0d cyc=%0d got %b want %b", d, cyc, rlg[d],
                     (cyc == exp_realign[d]));
          end
          if (st[d] === 1'b1) begin
            if (prev_start[d] >= 0) begin
              if (cyc - prev_start[d] < min_gap[d]) min_gap[d] = cyc - prev_start[d];
              if (cyc - prev_start[d] > max_gap[d]) max_gap[d] = cyc - prev_start[d];
            end
            prev_start[d] = cyc;
            starts_seen[d]++;
            last_start_seen[d] = cyc;
            first_a[d] = oa[d];
          end
          if (act[d] === 1'b1) active_seen[d]++;
          if (rlg[d] === 1'b1) realign_seen[d]++;
        end
      end
    end
  endtask

  task automatic send(int d, logic [7:0] x, logic sync);
    bit done = 1'b0;
    vld[d] = 1'b1; dat[d] = x; syn[d] = sync;
    for (int w = 0; w < 300 && !done; w++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        model_accept(d, x, sync, cyc);
        done = 1'b1;
      end else begin
        stalls[d]++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout dut%0d got no accept want accept within 300 cycles", d);
    end
  endtask

  task automatic idle(int d, int n);
    vld[d] = 1'b0; syn[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(int d, string name);
    int w = 0;
    vld[d] = 1'b0; syn[d] = 1'b0;
    while (expq[d].size() != 0 && w < 400) begin @(posedge clk); #1; w++; end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (expq[d].size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d want 0", name, expq[d].size());
    end
  endtask

  task automatic apply_reset();
    for (int d = 0; d < 2; d++) begin vld[d] = 1'b0; syn[d] = 1'b0; dat[d] = '0; end
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rdy[d] !== 1'b0 || act[d] !== 1'b0 || st[d] !== 1'b0 || rlg[d] !== 1'b0 ||
          oa[d] !== 8'd0 || ob[d] !== 8'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got rdy=%b act=%b start=%b rl=%b a=%0d b=%0d want all 0",
                 d, rdy[d], act[d], st[d], rlg[d], oa[d], ob[d]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rdy[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset_ready dut%0d got %b want 1", d, rdy[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_block();
    logic [7:0] v [16];
    int s0, a0;
    v = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd17, 8'd19, 8'd21,
          8'd22, 8'd18, 8'd18, 8'd16, 8'd8, 8'd6, 8'd4, 8'd2};
    apply_reset();
    s0 = starts_seen[0]; a0 = active_seen[0];
    for (int i = 0; i < N; i++) send(0, v[i], 1'b0);
    drain(0, "basic");
    total++;
    if (starts_seen[0] - s0 != 1) begin
      bad++; $display("FAIL basic_starts got %0d want 1", starts_seen[0] - s0);
    end
    total++;
    if (active_seen[0] - a0 != 8) begin
      bad++; $display("FAIL basic_active got %0d want 8", active_seen[0] - a0);
    end
    total++;
    if (last_start_seen[0] != last_acc[0] + 2) begin
      bad++; $display("FAIL basic_latency got %0d want %0d", last_start_seen[0], last_acc[0] + 2);
    end
    total++;
    if (first_a[0] !== 8'd1) begin
      bad++; $display("FAIL basic_first_a got %0d want 1", first_a[0]);
    end
  endtask

  task automatic test_continuous();
    int s0, st0;
    apply_reset();
    s0 = starts_seen[0]; st0 = stalls[0];
    for (int i = 0; i < 48; i++) send(0, 8'($urandom), 1'b0);
    drain(0, "cont");
    total++;
    if (stalls[0] != st0) begin
      bad++; $display("FAIL cont_ready got stalls=%0d want 0", stalls[0] - st0);
    end
    total++;
    if (starts_seen[0] - s0 != 3) begin
      bad++; $display("FAIL cont_starts got %0d want 3", starts_seen[0] - s0);
    end
    total++;
    if (min_gap[0] != 16 || max_gap[0] != 16) begin
      bad++; $display("FAIL cont_spacing got min=%0d max=%0d want 16", min_gap[0], max_gap[0]);
    end
  endtask

  task automatic test_backpressure();
    int s0, st0;
    apply_reset();
    s0 = starts_seen[1]; st0 = stalls[1];
    for (int i = 0; i < 64; i++) send(1, 8'($urandom), 1'b0);
    drain(1, "bp");
    total++;
    if (stalls[1] == st0) begin
      bad++; $display("FAIL bp_ready_drop got stalls=0 want >0");
    end
    total++;
    if (starts_seen[1] - s0 != 4) begin
      bad++; $display("FAIL bp_starts got %0d want 4", starts_seen[1] - s0);
    end
    total++;
    if (min_gap[1] < 40) begin
      bad++; $display("FAIL bp_spacing got min=%0d want >=40", min_gap[1]);
    end
  endtask

  task automatic test_sync_realign();
    int s0, r0;
    apply_reset();
    s0 = starts_seen[0]; r0 = realign_seen[0];
    send(0, 8'd90, 1'b1);  // sync at index 0 only marks the block start
    for (int i = 1; i < 5; i++) send(0, 8'(99 + i), 1'b0);
    send(0, 8'd200, 1'b1);
    for (int i = 1; i < N; i++) send(0, 8'(200 + i), 1'b0);
    drain(0, "sync");
    total++;
    if (realign_seen[0] - r0 != 1) begin
      bad++; $display("FAIL sync_realign_count got %0d want 1", realign_seen[0] - r0);
    end
    total++;
    if (starts_seen[0] - s0 != 1) begin
      bad++; $display("FAIL sync_starts got %0d want 1", starts_seen[0] - s0);
    end
    total++;
    if (first_a[0] !== 8'd200) begin
      bad++; $display("FAIL sync_first_a got %0d want 200", first_a[0]);
    end
  endtask

  task automatic test_reset_mid_stream();
    int s0, target, w;
    apply_reset();
    for (int i = 0; i < N; i++) send(0, 8'(16 + i), 1'b0);
    vld[0] = 1'b0;
    target = last_exp_start[0] + 3;
    w = 0;
    while (cyc < target && w < 50) begin @(posedge clk); #1; w++; end
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (act[0] !== 1'b0 || st[0] !== 1'b0 || oa[0] !== 8'd0 || ob[0] !== 8'd0 || rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs got act=%b start=%b a=%0d b=%0d rdy=%b want all 0",
               act[0], st[0], oa[0], ob[0], rdy[0]);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b1) begin
      bad++; $display("FAIL midreset_ready got %b want 1", rdy[0]);
    end
    @(posedge clk); #1;
    s0 = starts_seen[0];
    for (int i = 0; i < N - 1; i++) send(0, 8'($urandom), 1'b0);
    idle(0, 20);
    total++;
    if (starts_seen[0] != s0) begin
      bad++; $display("FAIL midreset_early_start got %0d want 0", starts_seen[0] - s0);
    end
    send(0, 8'($urandom), 1'b0);
    drain(0, "midreset");
    total++;
    if (starts_seen[0] - s0 != 1) begin
      bad++; $display("FAIL midreset_starts got %0d want 1", starts_seen[0] - s0);
    end
  endtask

  task automatic test_sparse_valid();
    logic [7:0] v [16];
    int s0;
    v = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd17, 8'd19, 8'd21,
          8'd22, 8'd18, 8'd18, 8'd16, 8'd8, 8'd6, 8'd4, 8'd2};
    apply_reset();
    s0 = starts_seen[0];
    for (int i = 0; i < N; i++) begin
      send(0, v[i], 1'b0);
      idle(0, 1);
    end
    drain(0, "sparse");
    total++;
    if (starts_seen[0] - s0 != 1) begin
      bad++; $display("FAIL sparse_starts got %0d want 1", starts_seen[0] - s0);
    end
    total++;
    if (last_start_seen[0] != last_acc[0] + 2) begin
      bad++; $display("FAIL sparse_latency got %0d want %0d", last_start_seen[0], last_acc[0] + 2);
    end
  endtask

  task automatic test_random();
    int s0, b0, r0, rm0;
    apply_reset();
    s0 = starts_seen[0]; b0 = blocks_made[0]; r0 = realign_seen[0]; rm0 = realigns_made[0];
    for (int i = 0; i < 96; i++) begin
      send(0, 8'($urandom), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(1, 2));
    end
    drain(0, "random");
    total++;
    if (starts_seen[0] - s0 != blocks_made[0] - b0) begin
      bad++;
      $display("FAIL random_starts got %0d want %0d", starts_seen[0] - s0, blocks_made[0] - b0);
    end
    total++;
    if (realign_seen[0] - r0 != realigns_made[0] - rm0) begin
      bad++;
      $display("FAIL random_realigns got %0d want %0d", realign_seen[0] - r0,
               realigns_made[0] - rm0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; syn[d] = 1'b0; dat[d] = '0;
      blocks_made[d] = 0; realigns_made[d] = 0; stalls[d] = 0; last_acc[d] = 0;
      starts_seen[d] = 0; active_seen[d] = 0; realign_seen[d] = 0; last_start_seen[d] = 0;
      first_a[d] = '0;
    end
    model_reset();
    fork
      monitor();
    join_none
    test_reset();
    test_basic_block();
    test_continuous();
    test_backpressure();
    test_sync_realign();
    test_reset_mid_stream();
    test_sparse_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
